// File: rtl/fio_init_sequencer.sv
// fio_init_sequencer: FileIO preload / run / dump sequencer.
// Loads NUM_CH target memories in channel order from a host word stream.
// It then holds the kernel start level until finished_i and streams back
// len[DUMP_CH] words of the dump channel through a READ_LAT-deep read pipeline.
// Optional build macro: FIO_TIMEOUT_EN adds a RUN watchdog of TIMEOUT_CYC cycles.
//
// Stream handshake: a host word transfers on every clock edge where s_valid
// and s_ready are both high. s_ready is high only in LOAD and never while clear
// is asserted. The dump stream (m_valid) has no ready; every m_valid cycle is
// one word.
module fio_init_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 256,
    parameter int ADDR_W      = 12,
    parameter int DUMP_CH     = 2,
    parameter int READ_LAT    = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go,
    input  logic                         clear,
    input  logic [NUM_CH*(ADDR_W+1)-1:0] ch_len,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_W-1:0]            s_data,
    output logic [NUM_CH-1:0]            wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [DATA_W-1:0]            wr_data,
    output logic                         start_o,
    input  logic                         finished_i,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic [DATA_W-1:0]            rd_data,
    output logic                         m_valid,
    output logic [ADDR_W-1:0]            m_addr,
    output logic [DATA_W-1:0]            m_data,
    output logic                         busy,
    output logic                         done_o,
    output logic                         timeout_o,
    output logic [2:0]                   state_dbg
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Configurations that cannot work: read latency outside 1..7, a dump
    // channel that does not exist, or a watchdog limit below one cycle.
    if (READ_LAT < 1 || READ_LAT > 7 || DUMP_CH >= NUM_CH || TIMEOUT_CYC < 1) begin : g_bad_config
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DUMP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state, state_nx;

    logic [NUM_CH-1:0][LEN_W-1:0]    len_q;
    logic [CH_W-1:0]                 ptr;
    logic [ADDR_W-1:0]               cnt;
    logic [LEN_W-1:0]                rd_cnt;
    logic [NUM_CH-1:0]               wr_en_q;
    logic [ADDR_W-1:0]               wr_addr_q;
    logic [DATA_W-1:0]               wr_data_q;
    logic                            start_q;
    logic [READ_LAT-1:0]             pv;
    logic [READ_LAT-1:0][ADDR_W-1:0] pa;

    logic [CH_W-1:0] first_nz, next_nz;
    logic            any_in, any_next;
    logic            go_accept, hs, last_word, issue, pend, timeout_hit;

    assign go_accept = go && !clear && (state == S_IDLE || state == S_DONE);
    assign s_ready   = (state == S_LOAD) && !clear;
    assign hs        = s_valid && s_ready;
    assign last_word = (({1'b0, cnt} + LEN_W'(1)) == len_q[ptr]);
    assign issue     = (state == S_DUMP) && !clear && (rd_cnt != len_q[DUMP_CH]);

    // Lowest nonzero channel of the incoming lengths, and the next nonzero latched channel above ptr.
    always_comb begin
        first_nz = '0;
        any_in   = 1'b0;
        next_nz  = '0;
        any_next = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (ch_len[c*LEN_W +: LEN_W] != '0) begin
                first_nz = CH_W'(c);
                any_in   = 1'b1;
            end
            if (c > int'(ptr) && len_q[c] != '0) begin
                next_nz  = CH_W'(c);
                any_next = 1'b1;
            end
        end
    end

    // Reads still in flight ahead of the output stage of the read pipeline.
    always_comb begin
        pend = 1'b0;
        for (int i = 0; i < READ_LAT - 1; i++) begin
            pend = pend | pv[i];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; clear overrides everything else.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (go) state_nx = any_in ? S_LOAD : S_START;
                end
                S_LOAD: begin
                    if (hs && last_word && !any_next) state_nx = S_START;
                end
                S_START: state_nx = S_RUN;
                S_RUN: begin
                    if (finished_i)       state_nx = S_DUMP;
                    else if (timeout_hit) state_nx = S_DONE;
                end
                S_DUMP: begin
                    if (rd_cnt == len_q[DUMP_CH] && !pend) state_nx = S_DONE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Load counters, registered write port, start level and read-latency pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q     <= '0;
            ptr       <= '0;
            cnt       <= '0;
            rd_cnt    <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            start_q   <= 1'b0;
            pv        <= '0;
            pa        <= '0;
        end else if (clear) begin
            ptr     <= '0;
            cnt     <= '0;
            rd_cnt  <= '0;
            wr_en_q <= '0;
            start_q <= 1'b0;
            pv      <= '0;
            pa      <= '0;
        end else begin
            wr_en_q <= '0;
            if (go_accept) begin
                len_q <= ch_len;
                ptr   <= first_nz;
                cnt   <= '0;
            end
            if (hs) begin
                wr_en_q[ptr] <= 1'b1;
                wr_addr_q    <= cnt;
                wr_data_q    <= s_data;
                if (last_word) begin
                    cnt <= '0;
                    ptr <= next_nz;
                end else begin
                    cnt <= cnt + ADDR_W'(1);
                end
            end
            start_q <= (state == S_START) ||
                       (state == S_RUN && !finished_i && !timeout_hit);
            if (state != S_DUMP) begin
                rd_cnt <= '0;
            end else if (issue) begin
                rd_cnt <= rd_cnt + LEN_W'(1);
            end
            pv[0] <= issue;
            pa[0] <= rd_cnt[ADDR_W-1:0];
            for (int i = 1; i < READ_LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

`ifdef FIO_TIMEOUT_EN
    logic [31:0] run_cnt;
    logic        timeout_q;

    assign timeout_hit = (state == S_RUN) && !finished_i &&
                         (run_cnt == 32'(TIMEOUT_CYC - 1));
    assign timeout_o   = timeout_q;

    // RUN-cycle watchdog; the flag survives into DONE until clear or a new go.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt   <= '0;
            timeout_q <= 1'b0;
        end else if (clear) begin
            run_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_RUN) run_cnt <= run_cnt + 32'd1;
            else                run_cnt <= '0;
            if (go_accept)        timeout_q <= 1'b0;
            else if (timeout_hit) timeout_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    // clear kills strobes in the same cycle, including a write already registered.
    assign wr_en     = wr_en_q & {NUM_CH{~clear}};
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign start_o   = start_q & ~clear;
    assign rd_addr   = issue ? rd_cnt[ADDR_W-1:0] : '0;
    assign m_valid   = pv[READ_LAT-1] & ~clear;
    assign m_addr    = pa[READ_LAT-1];
    assign m_data    = m_valid ? rd_data : '0;
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done_o    = (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_fio_init_sequencer.sv
// Directed bench for fio_init_sequencer: load ordering, stalls, run/dump,
// abort, zero lengths and (when FIO_TIMEOUT_EN is defined) the watchdog.
`timescale 1ns/1ps
module tb_fio_init_sequencer;

    localparam int NUM_CH      = 4;
    localparam int DATA_W      = 256;
    localparam int ADDR_W      = 12;
    localparam int DUMP_CH     = 2;
    localparam int READ_LAT    = 2;
    localparam int TIMEOUT_CYC = 20;
    localparam int LEN_W       = ADDR_W + 1;
    localparam int EXP_W       = 2 + ADDR_W + 64;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DUMP  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic                      clk_tb = 1'b0;
    logic                      rst;
    logic                      go;
    logic                      clear;
    logic [NUM_CH*LEN_W-1:0]   ch_len;
    logic                      s_valid;
    logic                      s_ready;
    logic [DATA_W-1:0]         s_data;
    logic [NUM_CH-1:0]         wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic                      start_o;
    logic                      finished_i;
    logic [ADDR_W-1:0]         rd_addr;
    logic [DATA_W-1:0]         rd_data;
    logic                      m_valid;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_data;
    logic                      busy;
    logic                      done_o;
    logic                      timeout_o;
    logic [2:0]                state_dbg;

    // clock / reset
    always #5 clk_tb = ~clk_tb;

    fio_init_sequencer #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .DUMP_CH(DUMP_CH), .READ_LAT(READ_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk_tb), .rst(rst), .go(go), .clear(clear), .ch_len(ch_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start_o(start_o), .finished_i(finished_i),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data),
        .busy(busy), .done_o(done_o), .timeout_o(timeout_o), .state_dbg(state_dbg)
    );

    // dump-channel memory model with a fixed two-cycle read latency
    logic [DATA_W-1:0] dump_mem [0:15];
    logic [ADDR_W-1:0] rd_d1 = '0;
    logic [ADDR_W-1:0] rd_d2 = '0;
    always @(posedge clk_tb) begin
        rd_d1 <= rd_addr;
        rd_d2 <= rd_d1;
    end
    assign rd_data = dump_mem[rd_d2[3:0]];

    // scoreboard
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_obs;
    logic [EXP_W-1:0] mon_exp;
    int pass_cnt  = 0;
    int total_cnt = 0;
    int n, mv_cnt, first_mv, last_mv, done_at, exp_a;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [DATA_W-1:0] word(input logic [31:0] v);
        return {32'hF00D_0000 | v, 192'd0, v};
    endfunction

    function automatic logic [EXP_W-1:0] exp_entry(input int ch, input int addr, input logic [31:0] v);
        return {2'(ch), ADDR_W'(addr), 32'hF00D_0000 | v, v};
    endfunction

    function automatic logic [1:0] ch_of(input logic [NUM_CH-1:0] v);
        ch_of = '0;
        for (int c = 0; c < NUM_CH; c++) if (v[c]) ch_of = 2'(c);
    endfunction

    function automatic logic [NUM_CH*LEN_W-1:0] pack_len(input int l0, input int l1, input int l2, input int l3);
        return {LEN_W'(l3), LEN_W'(l2), LEN_W'(l1), LEN_W'(l0)};
    endfunction

    // write monitor: every strobe must be one-hot and match the next expected write
    always @(negedge clk_tb) begin
        if (rst === 1'b1 && (|wr_en)) begin
            check("wr_onehot", DATA_W'($countones(wr_en)), DATA_W'(1));
            mon_obs = {ch_of(wr_en), wr_addr, wr_data[255:224], wr_data[31:0]};
            check("wr_expected_pending", DATA_W'(exp_q.size() != 0), DATA_W'(1));
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("wr_ch_addr_data", mon_obs, mon_exp);
            end
        end
    end

    // driver
    task automatic step();
        @(posedge clk_tb);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL tb_watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 16; k++) dump_mem[k] = {32'hC0DE_0000 + 32'(k), 192'd0, 32'h15 + 32'(k)};
        rst = 1'b1; go = 1'b0; clear = 1'b0; ch_len = '0;
        s_valid = 1'b0; s_data = '0; finished_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        // reset state
        check("rst_s_ready", s_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_start_o", start_o, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done_o", done_o, 0);
        check("rst_timeout_o", timeout_o, 0);
        check("rst_state", state_dbg, ST_IDLE);
        step(); step();
        rst = 1'b1;
        step();

        // load ch_len = {0,4,3,2}, 9 continuous words
        for (int i = 0; i < 2; i++) exp_q.push_back(exp_entry(0, i, 32'h10 + 32'(i)));
        for (int i = 0; i < 3; i++) exp_q.push_back(exp_entry(1, i, 32'h12 + 32'(i)));
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_entry(2, i, 32'h15 + 32'(i)));
        ch_len = pack_len(2, 3, 4, 0);
        go = 1'b1; step(); go = 1'b0;
        check("load_state", state_dbg, ST_LOAD);
        check("load_s_ready", s_ready, 1);
        check("load_busy", busy, 1);
        for (int i = 0; i < 9; i++) begin
            s_valid = 1'b1; s_data = word(32'h10 + 32'(i)); step();
        end
        s_valid = 1'b0;
        check("load_end_state", state_dbg, ST_START);
        check("load_end_s_ready", s_ready, 0);
        check("start_state_start_o", start_o, 0);
        step();
        check("load_all_written", DATA_W'(exp_q.size()), 0);
        check("run_state", state_dbg, ST_RUN);

        // run: finished_i 10 cycles after start_o rises
        n = 0;
        while (start_o && n < 40) begin
            finished_i = (n == 10); n++; step();
        end
        finished_i = 1'b0;
        check("start_high_cycles", DATA_W'(n), 11);
        check("dump_state", state_dbg, ST_DUMP);
        check("dump_rd_addr0", rd_addr, 0);

        // dump of channel 2, 4 words
        first_mv = -1; last_mv = -1; done_at = -1; mv_cnt = 0; exp_a = 0;
        for (int j = 0; j < 12; j++) begin
            if (m_valid) begin
                if (first_mv < 0) first_mv = j;
                check("dump_addr", m_addr, DATA_W'(exp_a));
                check("dump_data", m_data, dump_mem[exp_a[3:0]]);
                exp_a++; mv_cnt++; last_mv = j;
            end
            if (done_o && done_at < 0) done_at = j;
            step();
        end
        check("dump_count", DATA_W'(mv_cnt), 4);
        check("dump_first_cycle", DATA_W'(first_mv), 2);
        check("dump_last_cycle", DATA_W'(last_mv), 5);
        check("done_cycle", DATA_W'(done_at), 6);
        check("done_held", done_o, 1);
        check("done_busy", busy, 0);

        // stall handling: s_valid toggles, ch0 = 3
        for (int i = 0; i < 3; i++) exp_q.push_back(exp_entry(0, i, 32'h20 + 32'(i)));
        ch_len = pack_len(3, 0, 0, 0);
        go = 1'b1; step(); go = 1'b0;
        check("stall_state", state_dbg, ST_LOAD);
        check("stall_done_cleared", done_o, 0);
        for (int i = 0; i < 5; i++) begin
            s_valid = (i % 2 == 0);
            s_data  = s_valid ? word(32'h20 + 32'(i / 2)) : word(32'h99);
            step();
        end
        check("stall_s_ready_low", s_ready, 0);
        check("stall_end_state", state_dbg, ST_START);
        s_valid = 1'b1; s_data = word(32'h77);
        step();
        check("stall_all_written", DATA_W'(exp_q.size()), 0);
        finished_i = 1'b1; step(); finished_i = 1'b0; s_valid = 1'b0;
        check("zero_dump_state", state_dbg, ST_DUMP);
        check("zero_dump_m_valid", m_valid, 0);
        step();
        check("zero_dump_done", done_o, 1);
        check("zero_dump_m_valid2", m_valid, 0);

        // abort mid-LOAD after two handshakes
        exp_q.push_back(exp_entry(0, 0, 32'h30));
        ch_len = pack_len(4, 2, 0, 0);
        go = 1'b1; step(); go = 1'b0;
        s_valid = 1'b1; s_data = word(32'h30); step();
        s_data = word(32'h31); step();
        clear = 1'b1; s_data = word(32'h32); #1;
        check("abort_wr_suppressed", wr_en, 0);
        check("abort_s_ready", s_ready, 0);
        step(); clear = 1'b0;
        check("abort_state", state_dbg, ST_IDLE);
        check("abort_s_ready_idle", s_ready, 0);
        check("abort_busy", busy, 0);
        step();
        check("abort_no_wr", wr_en, 0);
        s_valid = 1'b0;
        check("abort_writes", DATA_W'(exp_q.size()), 0);

        // reload from addr 0, then clear during RUN
        exp_q.push_back(exp_entry(0, 0, 32'h40));
        exp_q.push_back(exp_entry(0, 1, 32'h41));
        ch_len = pack_len(2, 0, 0, 0);
        go = 1'b1; step(); go = 1'b0;
        s_valid = 1'b1; s_data = word(32'h40); step();
        s_data = word(32'h41); step(); s_valid = 1'b0;
        check("reload_state", state_dbg, ST_START);
        step();
        check("reload_writes", DATA_W'(exp_q.size()), 0);
        check("reload_start_o", start_o, 1);
        clear = 1'b1; #1;
        check("clear_start_o", start_o, 0);
        step(); clear = 1'b0;
        check("clear_run_state", state_dbg, ST_IDLE);
        check("clear_done_o", done_o, 0);

        // all lengths zero
        ch_len = '0;
        go = 1'b1; step(); go = 1'b0;
        check("zl_state", state_dbg, ST_START);
        check("zl_start_o_c1", start_o, 0);
        check("zl_s_ready", s_ready, 0);
        step();
        check("zl_start_o_c2", start_o, 1);
        finished_i = 1'b1; step(); finished_i = 1'b0;
        check("zl_dump_state", state_dbg, ST_DUMP);
        check("zl_start_dropped", start_o, 0);
        step();
        check("zl_done", done_o, 1);
        check("zl_m_valid", m_valid, 0);

`ifdef FIO_TIMEOUT_EN
        // watchdog with finished_i never asserted
        ch_len = '0;
        go = 1'b1; step(); go = 1'b0; step();
        check("to_run_state", state_dbg, ST_RUN);
        n = 0;
        while (!done_o && n < 40) begin
            check("to_no_m_valid", m_valid, 0);
            n++; step();
        end
        check("to_cycles", DATA_W'(n), 20);
        check("to_timeout_o", timeout_o, 1);
        check("to_start_o", start_o, 0);
        clear = 1'b1; step(); clear = 1'b0;
        check("to_cleared", timeout_o, 0);
`else
        check("timeout_tied_low", timeout_o, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
